// File: rtl/alu_control_dec_if.sv
// Instruction-field / ALU-op bundle between the control unit and alu_control_dec.
// The master drives instruction fields; the decoder (slave) returns the op code.
interface alu_control_dec_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       last_instr_flag_in;
    logic [3:0] alu_op;
    logic       halted;
    logic       illegal_op;

    modport master (
        output opcode, funct3, funct7, last_instr_flag_in,
        input  alu_op, halted, illegal_op
    );

    modport slave (
        input  opcode, funct3, funct7, last_instr_flag_in,
        output alu_op, halted, illegal_op
    );
endinterface

// File: rtl/alu_control_dec.sv
// RV32 ALU-operation decoder with end-of-program halt latch.
// Define ALU_EXT_OPS_EN for full RV32I ALU coverage (shifts, XOR, SLTU, LUI, AUIPC).
module alu_control_dec (
    input  logic               clk,
    input  logic               rst,
    alu_control_dec_if.slave   bus
);
    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_SLT    = 4'b0111;
    localparam logic [3:0] ALU_NOP    = 4'b1111;
`ifdef ALU_EXT_OPS_EN
    localparam logic [3:0] ALU_XOR    = 4'b0011;
    localparam logic [3:0] ALU_SLL    = 4'b0100;
    localparam logic [3:0] ALU_SRL    = 4'b0101;
    localparam logic [3:0] ALU_SRA    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;
`endif

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
`ifdef ALU_EXT_OPS_EN
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
`endif

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t     state;
    logic       active;
    logic [3:0] dec_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else if (bus.last_instr_flag_in) begin
            state <= HALT;
        end
    end

    assign bus.halted = (state == HALT);
    assign active     = !rst && !bus.last_instr_flag_in && (state == RUN);

    always_comb begin
        dec_op = ALU_NOP;
        case (bus.opcode)
            OPC_R: begin
                case (bus.funct3)
                    3'b000: begin
                        if (bus.funct7 == F7_BASE)     dec_op = ALU_ADD;
                        else if (bus.funct7 == F7_ALT) dec_op = ALU_SUB;
                    end
                    3'b111: dec_op = ALU_AND;
                    3'b110: dec_op = ALU_OR;
                    3'b010: dec_op = ALU_SLT;
`ifdef ALU_EXT_OPS_EN
                    3'b100: dec_op = ALU_XOR;
                    3'b011: dec_op = ALU_SLTU;
                    3'b001: begin
                        if (bus.funct7 == F7_BASE) dec_op = ALU_SLL;
                    end
                    3'b101: begin
                        if (bus.funct7 == F7_BASE)     dec_op = ALU_SRL;
                        else if (bus.funct7 == F7_ALT) dec_op = ALU_SRA;
                    end
`endif
                    default: dec_op = ALU_NOP;
                endcase
            end
            OPC_I: begin
                case (bus.funct3)
                    3'b000: dec_op = ALU_ADD;
                    3'b111: dec_op = ALU_AND;
                    3'b110: dec_op = ALU_OR;
                    3'b010: dec_op = ALU_SLT;
`ifdef ALU_EXT_OPS_EN
                    3'b100: dec_op = ALU_XOR;
                    3'b011: dec_op = ALU_SLTU;
                    3'b001: dec_op = ALU_SLL;
                    3'b101: dec_op = bus.funct7[5] ? ALU_SRA : ALU_SRL;
`endif
                    default: dec_op = ALU_NOP;
                endcase
            end
            OPC_LOAD, OPC_STORE: dec_op = ALU_ADD;
            OPC_BRANCH: begin
`ifdef ALU_EXT_OPS_EN
                case (bus.funct3)
                    3'b000, 3'b001: dec_op = ALU_SUB;
                    3'b100, 3'b101: dec_op = ALU_SLT;
                    3'b110, 3'b111: dec_op = ALU_SLTU;
                    default:        dec_op = ALU_NOP;
                endcase
`else
                dec_op = ALU_SUB;
`endif
            end
            OPC_JAL, OPC_JALR: dec_op = ALU_ADD;
`ifdef ALU_EXT_OPS_EN
            OPC_LUI:   dec_op = ALU_PASS_B;
            OPC_AUIPC: dec_op = ALU_ADD;
`endif
            default: dec_op = ALU_NOP;
        endcase
    end

    // Every legal encoding maps to a real op, so a NOP from the table means unsupported.
    assign bus.alu_op     = active ? dec_op : ALU_NOP;
    assign bus.illegal_op = active && (dec_op == ALU_NOP);
endmodule

// File: tb/tb_alu_control_dec.sv
// Directed testbench for alu_control_dec.
// Build with +define+ALU_EXT_OPS_EN to exercise the extended op table.
module tb_alu_control_dec;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    alu_control_dec_if bus ();

    alu_control_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7);
        bus.opcode = opc;
        bus.funct3 = f3;
        bus.funct7 = f7;
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.last_instr_flag_in = 1'b0;
        drive(7'b0110011, 3'b000, 7'b0000000);
        n_total++;
        if (bus.alu_op !== 4'b1111) $display("FAIL reset_alu_op got %b exp 1111", bus.alu_op);
        else n_pass++;
        n_total++;
        if (bus.illegal_op !== 1'b0) $display("FAIL reset_illegal got %b exp 0", bus.illegal_op);
        else n_pass++;
        edge_step();
        n_total++;
        if (bus.halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", bus.halted);
        else n_pass++;
        rst = 1'b0;
        edge_step();
    endtask

    task automatic test_rtype();
        logic [2:0] f3 [5] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
        logic [6:0] f7 [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
        logic [3:0] ex [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
        for (int i = 0; i < 5; i++) begin
            drive(7'b0110011, f3[i], f7[i]);
            n_total++;
            if (bus.alu_op !== ex[i] || bus.illegal_op !== 1'b0)
                $display("FAIL rtype_%0d got op=%b ill=%b exp op=%b ill=0",
                         i, bus.alu_op, bus.illegal_op, ex[i]);
            else n_pass++;
        end
        drive(7'b0110011, 3'b000, 7'b0000001);
        n_total++;
        if (bus.alu_op !== 4'b1111 || bus.illegal_op !== 1'b1)
            $display("FAIL rtype_bad_f7 got op=%b ill=%b exp op=1111 ill=1",
                     bus.alu_op, bus.illegal_op);
        else n_pass++;
    endtask

    task automatic test_imm_mem_ctrl();
        logic [6:0] opc [9] = '{7'b0010011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1100011, 7'b1101111, 7'b1100111,
                                7'b1111111};
        logic [2:0] f3  [9] = '{3'b000, 3'b111, 3'b010, 3'b010,
                                3'b000, 3'b001, 3'b000, 3'b000, 3'b000};
        logic [3:0] ex  [9] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010,
                                4'b0110, 4'b0110, 4'b0010, 4'b0010, 4'b1111};
        logic       il  [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 9; i++) begin
            drive(opc[i], f3[i], 7'h55);
            n_total++;
            if (bus.alu_op !== ex[i] || bus.illegal_op !== il[i])
                $display("FAIL imm_mem_ctrl_%0d got op=%b ill=%b exp op=%b ill=%b",
                         i, bus.alu_op, bus.illegal_op, ex[i], il[i]);
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        drive(7'b0110011, 3'b000, 7'b0000000);
        bus.last_instr_flag_in = 1'b1;
        #1;
        n_total++;
        if (bus.alu_op !== 4'b1111 || bus.illegal_op !== 1'b0)
            $display("FAIL halt_flag_cycle got op=%b ill=%b exp op=1111 ill=0",
                     bus.alu_op, bus.illegal_op);
        else n_pass++;
        edge_step();
        bus.last_instr_flag_in = 1'b0;
        #1;
        n_total++;
        if (bus.halted !== 1'b1) $display("FAIL halt_set got %b exp 1", bus.halted);
        else n_pass++;
        n_total++;
        if (bus.alu_op !== 4'b1111 || bus.illegal_op !== 1'b0)
            $display("FAIL halt_persist got op=%b ill=%b exp op=1111 ill=0",
                     bus.alu_op, bus.illegal_op);
        else n_pass++;
        edge_step();
        n_total++;
        if (bus.halted !== 1'b1) $display("FAIL halt_hold got %b exp 1", bus.halted);
        else n_pass++;
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
        #1;
        n_total++;
        if (bus.halted !== 1'b0) $display("FAIL halt_clear got %b exp 0", bus.halted);
        else n_pass++;
        n_total++;
        if (bus.alu_op !== 4'b0010) $display("FAIL halt_resume got %b exp 0010", bus.alu_op);
        else n_pass++;
    endtask

    task automatic test_rst_and_last();
        rst = 1'b1;
        bus.last_instr_flag_in = 1'b1;
        edge_step();
        n_total++;
        if (bus.halted !== 1'b0) $display("FAIL rst_last_same_edge got %b exp 0", bus.halted);
        else n_pass++;
        rst = 1'b0;
        bus.last_instr_flag_in = 1'b0;
        edge_step();
        n_total++;
        if (bus.halted !== 1'b0 || bus.alu_op !== 4'b0010)
            $display("FAIL rst_last_after got halted=%b op=%b exp halted=0 op=0010",
                     bus.halted, bus.alu_op);
        else n_pass++;
    endtask

`ifdef ALU_EXT_OPS_EN
    task automatic test_ext();
        logic [6:0] opc [8] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111,
                                7'b0110011, 7'b0010011, 7'b0010111, 7'b1100011};
        logic [2:0] f3  [8] = '{3'b101, 3'b011, 3'b110, 3'b000,
                                3'b100, 3'b101, 3'b000, 3'b010};
        logic [6:0] f7  [8] = '{7'h20, 7'h00, 7'h00, 7'h00,
                                7'h00, 7'h20, 7'h00, 7'h00};
        logic [3:0] ex  [8] = '{4'b1000, 4'b1001, 4'b1001, 4'b1010,
                                4'b0011, 4'b1000, 4'b0010, 4'b1111};
        logic       il  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            drive(opc[i], f3[i], f7[i]);
            n_total++;
            if (bus.alu_op !== ex[i] || bus.illegal_op !== il[i])
                $display("FAIL ext_%0d got op=%b ill=%b exp op=%b ill=%b",
                         i, bus.alu_op, bus.illegal_op, ex[i], il[i]);
            else n_pass++;
        end
    endtask
`else
    task automatic test_base_only();
        logic [6:0] opc [4] = '{7'b0110111, 7'b0110011, 7'b0010111, 7'b1100011};
        logic [2:0] f3  [4] = '{3'b000, 3'b100, 3'b000, 3'b110};
        logic [3:0] ex  [4] = '{4'b1111, 4'b1111, 4'b1111, 4'b0110};
        logic       il  [4] = '{1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            drive(opc[i], f3[i], 7'h00);
            n_total++;
            if (bus.alu_op !== ex[i] || bus.illegal_op !== il[i])
                $display("FAIL base_only_%0d got op=%b ill=%b exp op=%b ill=%b",
                         i, bus.alu_op, bus.illegal_op, ex[i], il[i]);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        bus.last_instr_flag_in = 1'b0;
        bus.opcode = '0;
        bus.funct3 = '0;
        bus.funct7 = '0;
        test_reset();
        test_rtype();
        test_imm_mem_ctrl();
        test_halt();
        test_rst_and_last();
`ifdef ALU_EXT_OPS_EN
        test_ext();
`else
        test_base_only();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
